// File: rtl/axil_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module      : axil_demux_1xn
// Description : AXI4-Lite 1-to-N address demultiplexer. The top SEL_WIDTH
//               address bits select a slave port. One write and one read
//               transaction are in flight at a time, and the two paths are
//               independent. Addresses that decode past M_COUNT are answered
//               locally with DECERR, so the bus never hangs.
//
// Ports       : clk, rst            - clock, synchronous active-high reset
//               s_aw*/s_w*/s_b*     - upstream write address/data/response
//               s_ar*/s_r*          - upstream read address/data
//               m_aw*/m_w*/m_b*     - per-slave write channels (packed)
//               m_ar*/m_r*          - per-slave read channels (packed)
//               err_valid/addr/write- sticky first decode-error record
//               err_clr             - one-cycle pulse that clears the record
//
// Options     : define AXIL_DEMUX_ERR_CAPTURE_EN to build the decode-error
//               capture registers. Without it, err_* are tied to 0 and
//               err_clr is ignored.
//
// Revision    : 1.0 - initial release
// ============================================================================

module axil_demux_1xn #(
    parameter int M_COUNT      = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int SEL_WIDTH    = 4,
    parameter int M_ADDR_WIDTH = 24,
    parameter int DATA_WIDTH   = 32,
    localparam int STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic [2:0]                     s_awprot,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [STRB_WIDTH-1:0]          s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic [2:0]                     s_arprot,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,

    output logic [M_COUNT*M_ADDR_WIDTH-1:0] m_awaddr,
    output logic [M_COUNT*3-1:0]           m_awprot,
    output logic [M_COUNT-1:0]             m_awvalid,
    input  logic [M_COUNT-1:0]             m_awready,
    output logic [M_COUNT*DATA_WIDTH-1:0]  m_wdata,
    output logic [M_COUNT*STRB_WIDTH-1:0]  m_wstrb,
    output logic [M_COUNT-1:0]             m_wvalid,
    input  logic [M_COUNT-1:0]             m_wready,
    input  logic [M_COUNT*2-1:0]           m_bresp,
    input  logic [M_COUNT-1:0]             m_bvalid,
    output logic [M_COUNT-1:0]             m_bready,
    output logic [M_COUNT*M_ADDR_WIDTH-1:0] m_araddr,
    output logic [M_COUNT*3-1:0]           m_arprot,
    output logic [M_COUNT-1:0]             m_arvalid,
    input  logic [M_COUNT-1:0]             m_arready,
    input  logic [M_COUNT*DATA_WIDTH-1:0]  m_rdata,
    input  logic [M_COUNT*2-1:0]           m_rresp,
    input  logic [M_COUNT-1:0]             m_rvalid,
    output logic [M_COUNT-1:0]             m_rready,

    output logic                           err_valid,
    output logic [ADDR_WIDTH-1:0]          err_addr,
    output logic                           err_write,
    input  logic                           err_clr
);

    localparam logic [1:0] C_RESP_DECERR = 2'b11;

    // Select field to one-hot slave vector. An all-zero result is a decode
    // error, so no separate range compare against M_COUNT is needed.
    function automatic logic [M_COUNT-1:0] decode(input logic [SEL_WIDTH-1:0] idx);
        logic [M_COUNT-1:0] sel;
        sel = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (idx == SEL_WIDTH'(i)) begin
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

    // ------------------------------------------------------------------------
    // Write path
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_RESP = 2'd2,
        W_ERR  = 2'd3
    } wstate_t;

    wstate_t                 r_wstate;
    logic                    r_aw_full;
    logic                    r_w_full;
    logic                    r_aw_done;
    logic                    r_w_done;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [2:0]              r_awprot;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_WIDTH-1:0]   r_wstrb;
    logic [M_COUNT-1:0]      r_wsel;

    logic                    w_aw_hs;
    logic                    w_w_hs;
    logic [ADDR_WIDTH-1:0]   w_aw_addr;
    logic [M_COUNT-1:0]      w_wdec;
    logic                    w_wstart;
    logic                    w_werr_entry;
    logic                    w_m_aw_hs;
    logic                    w_m_w_hs;
    logic                    w_sel_bvalid;
    logic [1:0]              w_sel_bresp;

    // Readies are masked by rst so the upstream sees 0 for the whole reset.
    assign s_awready = !rst && (r_wstate == W_IDLE) && !r_aw_full;
    assign s_wready  = !rst && (r_wstate == W_IDLE) && !r_w_full;

    assign w_aw_hs   = s_awvalid && s_awready;
    assign w_w_hs    = s_wvalid && s_wready;

    // Decode from whichever copy of the address is current, so the FSM can
    // leave IDLE in the same cycle that the second of AW/W is accepted.
    assign w_aw_addr    = w_aw_hs ? s_awaddr : r_awaddr;
    assign w_wdec       = decode(w_aw_addr[ADDR_WIDTH-1 -: SEL_WIDTH]);
    assign w_wstart     = (r_wstate == W_IDLE) && (r_aw_full || w_aw_hs) && (r_w_full || w_w_hs);
    assign w_werr_entry = w_wstart && !(|w_wdec);

    assign m_awvalid = r_wsel & {M_COUNT{(r_wstate == W_REQ) && !r_aw_done}};
    assign m_wvalid  = r_wsel & {M_COUNT{(r_wstate == W_REQ) && !r_w_done}};
    assign m_bready  = r_wsel & {M_COUNT{(r_wstate == W_RESP) && s_bready}};

    assign w_m_aw_hs    = |(m_awvalid & m_awready);
    assign w_m_w_hs     = |(m_wvalid & m_wready);
    assign w_sel_bvalid = |(m_bvalid & r_wsel);

    always_comb begin
        w_sel_bresp = 2'b00;
        for (int i = 0; i < M_COUNT; i++) begin
            if (r_wsel[i]) begin
                w_sel_bresp = w_sel_bresp | m_bresp[i*2 +: 2];
            end
        end
    end

    always_comb begin
        s_bvalid = 1'b0;
        s_bresp  = 2'b00;
        if (r_wstate == W_ERR) begin
            s_bvalid = 1'b1;
            s_bresp  = C_RESP_DECERR;
        end else if ((r_wstate == W_RESP) && w_sel_bvalid) begin
            s_bvalid = 1'b1;
            s_bresp  = w_sel_bresp;
        end
    end

    // Request fields are broadcast; only the selected slave sees a valid.
    assign m_awaddr = {M_COUNT{r_awaddr[M_ADDR_WIDTH-1:0]}};
    assign m_awprot = {M_COUNT{r_awprot}};
    assign m_wdata  = {M_COUNT{r_wdata}};
    assign m_wstrb  = {M_COUNT{r_wstrb}};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_awprot  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_wsel    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_full <= 1'b1;
                        r_awaddr  <= s_awaddr;
                        r_awprot  <= s_awprot;
                    end
                    if (w_w_hs) begin
                        r_w_full <= 1'b1;
                        r_wdata  <= s_wdata;
                        r_wstrb  <= s_wstrb;
                    end
                    if (w_wstart) begin
                        r_wsel    <= w_wdec;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_wstate  <= (|w_wdec) ? W_REQ : W_ERR;
                    end
                end
                W_REQ: begin
                    if (w_m_aw_hs) begin
                        r_aw_done <= 1'b1;
                    end
                    if (w_m_w_hs) begin
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || w_m_aw_hs) && (r_w_done || w_m_w_hs)) begin
                        r_wstate <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (s_bvalid && s_bready) begin
                        r_wstate  <= W_IDLE;
                        r_aw_full <= 1'b0;
                        r_w_full  <= 1'b0;
                        r_wsel    <= '0;
                    end
                end
                default: begin
                    if (s_bready) begin
                        r_wstate  <= W_IDLE;
                        r_aw_full <= 1'b0;
                        r_w_full  <= 1'b0;
                        r_wsel    <= '0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_REQ  = 2'd1,
        R_RESP = 2'd2,
        R_ERR  = 2'd3
    } rstate_t;

    rstate_t                 r_rstate;
    logic [M_ADDR_WIDTH-1:0] r_araddr;
    logic [2:0]              r_arprot;
    logic [M_COUNT-1:0]      r_rsel;

    logic                    w_ar_hs;
    logic [M_COUNT-1:0]      w_rdec;
    logic                    w_rerr_entry;
    logic                    w_sel_rvalid;
    logic [DATA_WIDTH-1:0]   w_sel_rdata;
    logic [1:0]              w_sel_rresp;

    assign s_arready    = !rst && (r_rstate == R_IDLE);
    assign w_ar_hs      = s_arvalid && s_arready;
    assign w_rdec       = decode(s_araddr[ADDR_WIDTH-1 -: SEL_WIDTH]);
    assign w_rerr_entry = w_ar_hs && !(|w_rdec);

    assign m_arvalid    = r_rsel & {M_COUNT{r_rstate == R_REQ}};
    assign m_rready     = r_rsel & {M_COUNT{(r_rstate == R_RESP) && s_rready}};
    assign m_araddr     = {M_COUNT{r_araddr}};
    assign m_arprot     = {M_COUNT{r_arprot}};
    assign w_sel_rvalid = |(m_rvalid & r_rsel);

    always_comb begin
        w_sel_rdata = '0;
        w_sel_rresp = 2'b00;
        for (int i = 0; i < M_COUNT; i++) begin
            if (r_rsel[i]) begin
                w_sel_rdata = w_sel_rdata | m_rdata[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_rresp = w_sel_rresp | m_rresp[i*2 +: 2];
            end
        end
    end

    always_comb begin
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_rresp  = 2'b00;
        if (r_rstate == R_ERR) begin
            s_rvalid = 1'b1;
            s_rresp  = C_RESP_DECERR;
        end else if ((r_rstate == R_RESP) && w_sel_rvalid) begin
            s_rvalid = 1'b1;
            s_rdata  = w_sel_rdata;
            s_rresp  = w_sel_rresp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_araddr <= '0;
            r_arprot <= '0;
            r_rsel   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_araddr <= s_araddr[M_ADDR_WIDTH-1:0];
                        r_arprot <= s_arprot;
                        r_rsel   <= w_rdec;
                        r_rstate <= (|w_rdec) ? R_REQ : R_ERR;
                    end
                end
                R_REQ: begin
                    if (|(m_arvalid & m_arready)) begin
                        r_rstate <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (s_rvalid && s_rready) begin
                        r_rstate <= R_IDLE;
                        r_rsel   <= '0;
                    end
                end
                default: begin
                    if (s_rready) begin
                        r_rstate <= R_IDLE;
                        r_rsel   <= '0;
                    end
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Decode-error capture
    // ------------------------------------------------------------------------
`ifdef AXIL_DEMUX_ERR_CAPTURE_EN
    logic                  r_err_valid;
    logic [ADDR_WIDTH-1:0] r_err_addr;
    logic                  r_err_write;
    logic                  w_err_open;

    // A clear in the same cycle as a new error re-arms the capture, so the
    // new error wins over the clear.
    assign w_err_open = !r_err_valid || err_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_write <= 1'b0;
        end else if (w_werr_entry && w_err_open) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= w_aw_addr;
            r_err_write <= 1'b1;
        end else if (w_rerr_entry && w_err_open) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= s_araddr;
            r_err_write <= 1'b0;
        end else if (err_clr) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_write <= 1'b0;
        end
    end

    assign err_valid = r_err_valid;
    assign err_addr  = r_err_addr;
    assign err_write = r_err_write;
`else
    assign err_valid = 1'b0;
    assign err_addr  = '0;
    assign err_write = 1'b0;
`endif

    // Sink for address bits and error strobes that only the optional capture
    // logic consumes.
    logic w_unused_bits;
    assign w_unused_bits = &{1'b0, err_clr, s_araddr, r_awaddr, w_werr_entry, w_rerr_entry};

endmodule

`default_nettype wire

// File: tb/tb_axil_demux_1xn.sv
`default_nettype none
// ============================================================================
// Module      : tb_axil_demux_1xn
// Description : Directed self-checking bench for axil_demux_1xn (M_COUNT=4).
//               Expected B/R responses are queued when a request is issued
//               and popped when the upstream response appears.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_axil_demux_1xn;

    localparam int M   = 4;
    localparam int AW  = 32;
    localparam int MAW = 24;
    localparam int DW  = 32;
    localparam int SW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   s_awaddr;
    logic [2:0]      s_awprot;
    logic            s_awvalid;
    logic            s_awready;
    logic [DW-1:0]   s_wdata;
    logic [SW-1:0]   s_wstrb;
    logic            s_wvalid;
    logic            s_wready;
    logic [1:0]      s_bresp;
    logic            s_bvalid;
    logic            s_bready;
    logic [AW-1:0]   s_araddr;
    logic [2:0]      s_arprot;
    logic            s_arvalid;
    logic            s_arready;
    logic [DW-1:0]   s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rvalid;
    logic            s_rready;
    logic [M*MAW-1:0] m_awaddr;
    logic [M*3-1:0]  m_awprot;
    logic [M-1:0]    m_awvalid;
    logic [M-1:0]    m_awready;
    logic [M*DW-1:0] m_wdata;
    logic [M*SW-1:0] m_wstrb;
    logic [M-1:0]    m_wvalid;
    logic [M-1:0]    m_wready;
    logic [M*2-1:0]  m_bresp;
    logic [M-1:0]    m_bvalid;
    logic [M-1:0]    m_bready;
    logic [M*MAW-1:0] m_araddr;
    logic [M*3-1:0]  m_arprot;
    logic [M-1:0]    m_arvalid;
    logic [M-1:0]    m_arready;
    logic [M*DW-1:0] m_rdata;
    logic [M*2-1:0]  m_rresp;
    logic [M-1:0]    m_rvalid;
    logic [M-1:0]    m_rready;
    logic            err_valid;
    logic [AW-1:0]   err_addr;
    logic            err_write;
    logic            err_clr;

    axil_demux_1xn #(
        .M_COUNT      (M),
        .ADDR_WIDTH   (AW),
        .SEL_WIDTH    (4),
        .M_ADDR_WIDTH (MAW),
        .DATA_WIDTH   (DW)
    ) dut (
        .clk (clk), .rst (rst),
        .s_awaddr (s_awaddr), .s_awprot (s_awprot), .s_awvalid (s_awvalid), .s_awready (s_awready),
        .s_wdata (s_wdata), .s_wstrb (s_wstrb), .s_wvalid (s_wvalid), .s_wready (s_wready),
        .s_bresp (s_bresp), .s_bvalid (s_bvalid), .s_bready (s_bready),
        .s_araddr (s_araddr), .s_arprot (s_arprot), .s_arvalid (s_arvalid), .s_arready (s_arready),
        .s_rdata (s_rdata), .s_rresp (s_rresp), .s_rvalid (s_rvalid), .s_rready (s_rready),
        .m_awaddr (m_awaddr), .m_awprot (m_awprot), .m_awvalid (m_awvalid), .m_awready (m_awready),
        .m_wdata (m_wdata), .m_wstrb (m_wstrb), .m_wvalid (m_wvalid), .m_wready (m_wready),
        .m_bresp (m_bresp), .m_bvalid (m_bvalid), .m_bready (m_bready),
        .m_araddr (m_araddr), .m_arprot (m_arprot), .m_arvalid (m_arvalid), .m_arready (m_arready),
        .m_rdata (m_rdata), .m_rresp (m_rresp), .m_rvalid (m_rvalid), .m_rready (m_rready),
        .err_valid (err_valid), .err_addr (err_addr), .err_write (err_write), .err_clr (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    rexp_t      q_r[$];
    logic [1:0] q_b[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for s_rvalid and checks it against the oldest queued read.
    task automatic wait_r(input string tag, output int lat);
        rexp_t e;
        lat = 0;
        while (!s_rvalid && lat < 20) begin
            tick();
            settle();
            lat++;
        end
        e = q_r.pop_front();
        chk({tag, "_rvalid"}, 64'(s_rvalid), 64'd1);
        chk({tag, "_rdata"}, 64'(s_rdata), 64'(e.data));
        chk({tag, "_rresp"}, 64'(s_rresp), 64'(e.resp));
    endtask

    task automatic wait_b(input string tag, output int lat);
        logic [1:0] e;
        lat = 0;
        while (!s_bvalid && lat < 20) begin
            tick();
            settle();
            lat++;
        end
        e = q_b.pop_front();
        chk({tag, "_bvalid"}, 64'(s_bvalid), 64'd1);
        chk({tag, "_bresp"}, 64'(s_bresp), 64'(e));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        int lat;
        rst = 1'b1;
        s_awaddr = '0; s_awprot = '0; s_awvalid = 1'b0;
        s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = '0; s_arprot = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        m_awready = '0; m_wready = '0; m_bresp = '0; m_bvalid = '0;
        m_arready = '0; m_rdata = '0; m_rresp = '0; m_rvalid = '0;
        err_clr = 1'b0;

        // ---- reset state ----
        tick(); tick(); settle();
        chk("rst_awready", 64'(s_awready), 64'd0);
        chk("rst_wready", 64'(s_wready), 64'd0);
        chk("rst_arready", 64'(s_arready), 64'd0);
        chk("rst_bvalid", 64'(s_bvalid), 64'd0);
        chk("rst_rvalid", 64'(s_rvalid), 64'd0);
        chk("rst_m_awvalid", 64'(m_awvalid), 64'd0);
        chk("rst_m_arvalid", 64'(m_arvalid), 64'd0);
        chk("rst_err", 64'({err_valid, err_write, err_addr}), 64'd0);
        rst = 1'b0;
        settle();
        chk("post_rst_readies", 64'({s_awready, s_wready, s_arready}), 64'b111);

        // ---- T1: read 0x1000_0040 from slave 1 ----
        tick();
        m_arready = 4'b0010; m_rvalid = 4'b0010; m_rresp = 8'b11_11_00_11;
        m_rdata = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h0000_1111};
        s_araddr = 32'h1000_0040; s_arprot = 3'b010; s_arvalid = 1'b1; s_rready = 1'b1;
        q_r.push_back('{32'hDEAD_BEEF, 2'b00});
        settle();
        chk("t1_arready", 64'(s_arready), 64'd1);
        tick();
        s_arvalid = 1'b0;
        settle();
        chk("t1_m_arvalid", 64'(m_arvalid), 64'b0010);
        chk("t1_m_araddr", 64'(m_araddr[1*MAW +: MAW]), 64'h00_0040);
        chk("t1_m_arprot", 64'(m_arprot[1*3 +: 3]), 64'b010);
        wait_r("t1", lat);
        chk("t1_latency", 64'(lat), 64'd1);
        chk("t1_m_rready", 64'(m_rready), 64'b0010);
        chk("t1_m_arvalid_off", 64'(m_arvalid), 64'd0);
        tick(); settle();
        chk("t1_rvalid_drop", 64'(s_rvalid), 64'd0);

        // ---- T2: write 0x2000_0010, W three cycles ahead of AW ----
        tick();
        m_awready = 4'b0100; m_wready = 4'b0100; m_bvalid = 4'b0100; m_bresp = 8'b11_00_01_01;
        s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
        settle();
        chk("t2_wready", 64'(s_wready), 64'd1);
        tick();
        s_wvalid = 1'b0;
        settle();
        chk("t2_wready_held", 64'(s_wready), 64'd0);
        chk("t2_awvalid_idle", 64'(m_awvalid), 64'd0);
        tick(); tick();
        s_awaddr = 32'h2000_0010; s_awprot = 3'b000; s_awvalid = 1'b1;
        q_b.push_back(2'b00);
        settle();
        chk("t2_awready", 64'(s_awready), 64'd1);
        tick();
        s_awvalid = 1'b0;
        settle();
        chk("t2_m_awvalid", 64'(m_awvalid), 64'b0100);
        chk("t2_m_wvalid", 64'(m_wvalid), 64'b0100);
        chk("t2_m_awaddr", 64'(m_awaddr[2*MAW +: MAW]), 64'h00_0010);
        chk("t2_m_wdata", 64'(m_wdata[2*DW +: DW]), 64'h1234_5678);
        chk("t2_m_wstrb", 64'(m_wstrb[2*SW +: SW]), 64'hF);
        chk("t2_bvalid_early", 64'(s_bvalid), 64'd0);
        wait_b("t2", lat);
        chk("t2_latency", 64'(lat), 64'd1);
        chk("t2_m_bready", 64'(m_bready), 64'b0100);
        tick(); settle();
        chk("t2_bvalid_drop", 64'(s_bvalid), 64'd0);

        // ---- T3: unmapped read 0x7000_0000 ----
        tick();
        m_arready = 4'b1111; m_rvalid = 4'b1111; m_rresp = 8'b0;
        m_rdata = {4{32'h5A5A_5A5A}};
        s_araddr = 32'h7000_0000; s_arvalid = 1'b1; s_rready = 1'b1;
        q_r.push_back('{32'h0, 2'b11});
        settle();
        chk("t3_arready", 64'(s_arready), 64'd1);
        tick();
        s_arvalid = 1'b0;
        settle();
        chk("t3_no_arvalid", 64'(m_arvalid), 64'd0);
`ifdef AXIL_DEMUX_ERR_CAPTURE_EN
        chk("t3_err_valid", 64'(err_valid), 64'd1);
        chk("t3_err_addr", 64'(err_addr), 64'h7000_0000);
        chk("t3_err_write", 64'(err_write), 64'd0);
`else
        chk("t3_err_tied", 64'({err_valid, err_write, err_addr}), 64'd0);
`endif
        wait_r("t3", lat);
        chk("t3_latency", 64'(lat), 64'd0);
        chk("t3_no_rready", 64'(m_rready), 64'd0);
        tick(); settle();
        chk("t3_rvalid_drop", 64'(s_rvalid), 64'd0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        settle();
        chk("t3_err_clr", 64'(err_valid), 64'd0);

        // ---- T4: slave 3 AW backpressure, then B backpressure ----
        tick();
        m_arready = '0; m_rvalid = '0;
        m_awready = 4'b0000; m_wready = 4'b1000; m_bvalid = 4'b1000; m_bresp = 8'b01_00_00_00;
        s_bready = 1'b0;
        s_awaddr = 32'h3000_0100; s_awprot = 3'b001; s_awvalid = 1'b1;
        s_wdata = 32'hA5A5_A5A5; s_wstrb = 4'h3; s_wvalid = 1'b1;
        q_b.push_back(2'b01);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        settle();
        for (int k = 0; k < 5; k++) begin
            chk("t4_awvalid_hold", 64'(m_awvalid), 64'b1000);
            chk("t4_awaddr_hold", 64'(m_awaddr[3*MAW +: MAW]), 64'h00_0100);
            chk("t4_no_new_aw", 64'(s_awready), 64'd0);
            chk("t4_wvalid", 64'(m_wvalid), (k == 0) ? 64'b1000 : 64'b0000);
            chk("t4_bvalid_req", 64'(s_bvalid), 64'd0);
            tick(); settle();
        end
        m_awready = 4'b1000;
        settle();
        chk("t4_awvalid_last", 64'(m_awvalid), 64'b1000);
        tick(); settle();
        for (int k = 0; k < 3; k++) begin
            chk("t4_bvalid_hold", 64'(s_bvalid), 64'd1);
            chk("t4_bresp_hold", 64'(s_bresp), 64'b01);
            chk("t4_bready_low", 64'(m_bready), 64'd0);
            chk("t4_no_new_aw_b", 64'(s_awready), 64'd0);
            tick(); settle();
        end
        s_bready = 1'b1;
        settle();
        wait_b("t4", lat);
        chk("t4_latency", 64'(lat), 64'd0);
        chk("t4_m_bready", 64'(m_bready), 64'b1000);
        tick(); settle();
        chk("t4_single_b", 64'(s_bvalid), 64'd0);
        chk("t4_aw_reopen", 64'(s_awready), 64'd1);

        // ---- T5: concurrent write to slave 0 and read from slave 1 ----
        tick();
        m_awready = 4'b0001; m_wready = 4'b0001; m_bvalid = 4'b0001; m_bresp = 8'b11_11_11_00;
        m_arready = 4'b0010; m_rvalid = 4'b0010; m_rresp = 8'b11_11_00_11;
        m_rdata = {32'h0, 32'h0, 32'hCAFE_F00D, 32'h1111_1111};
        s_awaddr = 32'h0000_0020; s_awvalid = 1'b1;
        s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b1;
        s_araddr = 32'h1000_0080; s_arvalid = 1'b1; s_rready = 1'b1;
        q_b.push_back(2'b00);
        q_r.push_back('{32'hCAFE_F00D, 2'b00});
        settle();
        chk("t5_readies", 64'({s_awready, s_wready, s_arready}), 64'b111);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        settle();
        chk("t5_m_awvalid", 64'(m_awvalid), 64'b0001);
        chk("t5_m_wvalid", 64'(m_wvalid), 64'b0001);
        chk("t5_m_arvalid", 64'(m_arvalid), 64'b0010);
        chk("t5_m_awaddr", 64'(m_awaddr[0 +: MAW]), 64'h00_0020);
        chk("t5_m_araddr", 64'(m_araddr[1*MAW +: MAW]), 64'h00_0080);
        tick(); settle();
        wait_b("t5w", lat);
        chk("t5w_latency", 64'(lat), 64'd0);
        wait_r("t5r", lat);
        chk("t5r_latency", 64'(lat), 64'd0);
        tick(); settle();
        chk("t5_done", 64'({s_bvalid, s_rvalid}), 64'd0);

        // ---- T6: write error then read error; capture keeps the first ----
        tick();
        m_awready = '0; m_wready = '0; m_bvalid = '0; m_arready = '0; m_rvalid = '0;
        s_awaddr = 32'h5000_0004; s_awvalid = 1'b1;
        s_wdata = 32'hFFFF_0000; s_wvalid = 1'b1; s_bready = 1'b1;
        q_b.push_back(2'b11);
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        settle();
        chk("t6_no_awvalid", 64'({m_awvalid, m_wvalid}), 64'd0);
`ifdef AXIL_DEMUX_ERR_CAPTURE_EN
        chk("t6_werr", 64'({err_valid, err_write, err_addr}), {31'd0, 1'b1, 1'b1, 32'h5000_0004});
`else
        chk("t6_werr_tied", 64'({err_valid, err_write, err_addr}), 64'd0);
`endif
        wait_b("t6w", lat);
        chk("t6w_latency", 64'(lat), 64'd0);
        tick();
        s_araddr = 32'h6000_0000; s_arvalid = 1'b1; s_rready = 1'b1;
        q_r.push_back('{32'h0, 2'b11});
        tick();
        s_arvalid = 1'b0;
        settle();
        wait_r("t6r", lat);
        chk("t6r_latency", 64'(lat), 64'd0);
`ifdef AXIL_DEMUX_ERR_CAPTURE_EN
        chk("t6_err_sticky", 64'({err_valid, err_write, err_addr}), {31'd0, 1'b1, 1'b1, 32'h5000_0004});
`else
        chk("t6_err_sticky_tied", 64'({err_valid, err_write, err_addr}), 64'd0);
`endif
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        settle();
        chk("t6_err_clr", 64'(err_valid), 64'd0);

        // ---- T7: reset during a stalled write drops the request ----
        tick();
        m_awready = '0; m_wready = '0;
        s_awaddr = 32'h2000_0000; s_awvalid = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        settle();
        chk("t7_pending", 64'(m_awvalid), 64'b0100);
        rst = 1'b1;
        settle();
        chk("t7_rst_awready", 64'(s_awready), 64'd0);
        tick(); settle();
        chk("t7_rst_valids", 64'({m_awvalid, m_wvalid, s_bvalid}), 64'd0);
        rst = 1'b0;
        m_awready = 4'b0100; m_wready = 4'b0100;
        settle();
        chk("t7_readies", 64'({s_awready, s_wready}), 64'b11);
        tick(); settle();
        chk("t7_dropped", 64'({m_awvalid, m_wvalid}), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
